fixed_point_butterfly_arbiter: RTL and testbench



---
 rtl/fixed_point_butterfly_arbiter.sv | 145 ++++++++++++++
 tb/tb_fixed_point_butterfly_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_butterfly_arbiter.sv
// Round-robin arbiter that time-shares one fixed-point butterfly between NREQ requesters.
// One operation in flight at a time: grant, issue to the butterfly, wait for the result, return it.
module fixed_point_butterfly_arbiter #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int b    = 4,
    parameter int NREQ = 3,
    localparam int OPW = 6 * n * b,
    localparam int RSW = 4 * n * b,
    localparam int OW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*OPW-1:0]  req_data,
    output logic [NREQ-1:0]      resp_val,
    input  logic [NREQ-1:0]      resp_rdy,
    output logic [RSW-1:0]       resp_data,
    output logic                 bf_reset,
    output logic                 bf_recv_val,
    input  logic                 bf_recv_rdy,
    input  logic                 bf_send_val,
    output logic                 bf_send_rdy,
    output logic [OPW-1:0]       bf_op,
    input  logic [RSW-1:0]       bf_res,
    output logic                 busy,
    output logic [OW-1:0]        owner
);

    if (NREQ < 2 || d >= n) begin : g_param_check
        $error("fixed_point_butterfly_arbiter: need NREQ >= 2 and d < n");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   ptr_reg, owner_reg, grant_idx;
    logic [OW:0]     cand;
    logic [NREQ-1:0] grant_onehot, owner_onehot;
    logic            grant_any, grant_fire, res_fire, resp_fire;
    logic [OPW-1:0]  op_reg, grant_data;
    logic [RSW-1:0]  res_reg;
    logic [1:0]      bf_sync_reg;

    // The butterfly's reset is released two edges after ours, synchronously to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bf_sync_reg <= 2'b11;
        else        bf_sync_reg <= {bf_sync_reg[0], 1'b0};
    end
    assign bf_reset = bf_sync_reg[1];

    // First valid requester at or after ptr, searching cyclically.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_reg} + (OW+1)'(i);
            if (cand >= (OW+1)'(NREQ)) cand = cand - (OW+1)'(NREQ);
            if (!grant_any && req_val[cand[OW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[OW-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign grant_onehot[gi] = (grant_idx == OW'(gi));
        assign owner_onehot[gi] = (owner_reg == OW'(gi));
        assign req_rdy[gi]      = grant_fire & grant_onehot[gi];
        assign resp_val[gi]     = (state_reg == RESP) & owner_onehot[gi];
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_onehot[i]) grant_data = req_data[i*OPW +: OPW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        grant_fire  = 1'b0;
        res_fire    = 1'b0;
        resp_fire   = 1'b0;
        bf_recv_val = 1'b0;
        bf_send_rdy = 1'b0;
        busy        = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (!bf_reset && grant_any) begin
                    grant_fire = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bf_recv_val = 1'b1;
                if (bf_recv_rdy) state_next = WAIT;
            end
            WAIT: begin
                bf_send_rdy = 1'b1;
                if (bf_send_val) begin
                    res_fire   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // Only the owner's resp_rdy can complete the response.
                if (|(resp_rdy & owner_onehot)) begin
                    resp_fire  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg    <= '0;
            res_reg   <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            if (grant_fire) begin
                op_reg    <= grant_data;
                owner_reg <= grant_idx;
            end
            if (res_fire) res_reg <= bf_res;
            if (resp_fire) ptr_reg <= (owner_reg == OW'(NREQ-1)) ? '0 : owner_reg + OW'(1);
        end
    end

    assign bf_op     = op_reg;
    assign resp_data = res_reg;
    assign owner     = owner_reg;

endmodule

// File: tb/tb_fixed_point_butterfly_arbiter.sv
// Bench for fixed_point_butterfly_arbiter: behavioural butterfly stand-in, round-robin
// reference model and result scoreboard; directed scenarios followed by random operations.
module tb_fixed_point_butterfly_arbiter;
    localparam int N    = 32;
    localparam int D    = 16;
    localparam int B    = 4;
    localparam int NREQ = 3;
    localparam int OPW  = 6 * N * B;
    localparam int RSW  = 4 * N * B;
    localparam int OW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_val = '0;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ*OPW-1:0] req_data = '0;
    logic [NREQ-1:0]     resp_val;
    logic [NREQ-1:0]     resp_rdy = '0;
    logic [RSW-1:0]      resp_data;
    logic                bf_reset, bf_recv_val, bf_send_rdy, busy;
    logic                bf_recv_rdy = 1'b1;
    logic                bf_send_val = 1'b0;
    logic [OPW-1:0]      bf_op;
    logic [RSW-1:0]      bf_res = '0;
    logic [OW-1:0]       owner;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_ptr = 0;

    fixed_point_butterfly_arbiter #(.n(N), .d(D), .b(B), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .bf_reset(bf_reset), .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy),
        .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy),
        .bf_op(bf_op), .bf_res(bf_res), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Complex butterfly per lane: c = a + b*w, d = a - b*w, products scaled by 2^-D.
    function automatic logic [RSW-1:0] bf_func(input logic [OPW-1:0] op);
        logic [RSW-1:0] r;
        logic signed [N-1:0] ar, ac, br, bc, wr, wc;
        longint pr, pi;
        r = '0;
        for (int l = 0; l < B; l++) begin
            ar = op[5*N*B + l*N +: N];
            ac = op[4*N*B + l*N +: N];
            br = op[3*N*B + l*N +: N];
            bc = op[2*N*B + l*N +: N];
            wr = op[1*N*B + l*N +: N];
            wc = op[l*N +: N];
            pr = (longint'(br) * longint'(wr) - longint'(bc) * longint'(wc)) >>> D;
            pi = (longint'(br) * longint'(wc) + longint'(bc) * longint'(wr)) >>> D;
            r[3*N*B + l*N +: N] = ar + N'(pr);
            r[2*N*B + l*N +: N] = ac + N'(pi);
            r[1*N*B + l*N +: N] = ar - N'(pr);
            r[l*N +: N]         = ac - N'(pi);
        end
        return r;
    endfunction

    // Butterfly stand-in: result appears B cycles after the cycle following the input handshake.
    logic           sb_busy = 1'b0;
    int             sb_cnt = 0;
    logic [OPW-1:0] sb_op = '0;
    always @(posedge clk) begin
        if (bf_reset) begin
            sb_busy     <= 1'b0;
            sb_cnt      <= 0;
            bf_send_val <= 1'b0;
        end else if (!sb_busy) begin
            if (bf_recv_val && bf_recv_rdy) begin
                sb_busy <= 1'b1;
                sb_cnt  <= B;
                sb_op   <= bf_op;
            end
        end else if (bf_send_val) begin
            if (bf_send_rdy) begin
                bf_send_val <= 1'b0;
                sb_busy     <= 1'b0;
            end
        end else if (sb_cnt > 1) begin
            sb_cnt <= sb_cnt - 1;
        end else begin
            sb_cnt      <= 0;
            bf_send_val <= 1'b1;
            bf_res      <= bf_func(sb_op);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One complete operation from whichever requester the model says should win.
    task automatic serve(input string tag, input int recv_stall, input int resp_stall);
        int g, t0, w;
        logic [NREQ-1:0] oh;
        logic [OPW-1:0] op;
        logic [RSW-1:0] held;
        #1;
        w = 0;
        while (req_rdy == '0 && w < 20) begin tick; w++; end
        g  = model_pick(req_val);
        oh = (g < 0) ? '0 : NREQ'(1 << g);
        check({tag, ".grant"}, OPW'(req_rdy), OPW'(oh));
        if (g < 0 || req_rdy != oh) return;
        op = req_data[g*OPW +: OPW];
        t0 = cyc;
        bf_recv_rdy = (recv_stall == 0);
        tick;
        check({tag, ".owner"}, OPW'(owner), OPW'(g));
        check({tag, ".issue_val"}, OPW'(bf_recv_val), OPW'(1));
        check({tag, ".issue_op"}, bf_op, op);
        check({tag, ".busy_no_rdy"}, OPW'(req_rdy), '0);
        for (int i = 0; i < recv_stall; i++) begin
            tick;
            check({tag, ".stall_val"}, OPW'(bf_recv_val), OPW'(1));
            check({tag, ".stall_op"}, bf_op, op);
        end
        bf_recv_rdy = 1'b1;
        w = 0;
        while (resp_val == '0 && w < 40) begin tick; w++; end
        check({tag, ".latency"}, OPW'(cyc - t0), OPW'(B + 3 + recv_stall));
        check({tag, ".resp_val"}, OPW'(resp_val), OPW'(oh));
        check({tag, ".resp_data"}, OPW'(resp_data), OPW'(bf_func(op)));
        held = resp_data;
        for (int i = 0; i < resp_stall; i++) begin
            resp_rdy = ~oh;
            tick;
            check({tag, ".bp_val"}, OPW'(resp_val), OPW'(oh));
            check({tag, ".bp_data"}, OPW'(resp_data), OPW'(held));
            check({tag, ".bp_no_rdy"}, OPW'(req_rdy), '0);
        end
        resp_rdy = oh;
        tick;
        resp_rdy = '0;
        check({tag, ".busy_after"}, OPW'(busy), '0);
        check({tag, ".resp_cleared"}, OPW'(resp_val), '0);
        model_ptr = (g + 1) % NREQ;
    endtask

    initial begin
        logic [OPW-1:0] op1, op;
        logic [RSW-1:0] res1;
        int w;
        op1  = {{4{32'h0002_0000}}, 128'h0, {4{32'h0001_0000}}, 128'h0, {4{32'h0001_0000}}, 128'h0};
        res1 = {{4{32'h0003_0000}}, 128'h0, {4{32'h0001_0000}}, 128'h0};

        // Reset state, with requests already pending.
        req_val = '1;
        tick; tick;
        check("rst.busy", OPW'(busy), '0);
        check("rst.req_rdy", OPW'(req_rdy), '0);
        check("rst.resp_val", OPW'(resp_val), '0);
        check("rst.recv_val", OPW'(bf_recv_val), '0);
        check("rst.send_rdy", OPW'(bf_send_rdy), '0);
        check("rst.bf_reset", OPW'(bf_reset), OPW'(1));
        check("rst.owner", OPW'(owner), '0);
        check("rst.bf_op", bf_op, '0);
        check("rst.resp_data", OPW'(resp_data), '0);
        req_val = '0;
        reset = 1'b1;
        tick;
        check("rel.bf_reset_1", OPW'(bf_reset), OPW'(1));
        tick;
        check("rel.bf_reset_2", OPW'(bf_reset), '0);

        // Single operation with known numbers.
        req_data[1*OPW +: OPW] = op1;
        req_val = 3'b010;
        #1;
        check("single.same_cycle_rdy", OPW'(req_rdy), OPW'(3'b010));
        req_val = '0;
        req_val[1] = 1'b1;
        serve("single", 0, 0);
        req_val = '0;
        check("single.const_result", OPW'(dut.res_reg), OPW'(res1));

        // Reset while the butterfly result is pending.
        req_val = 3'b010;
        #1;
        w = 0;
        while (req_rdy == '0 && w < 20) begin tick; w++; end
        check("rstwait.grant", OPW'(req_rdy), OPW'(3'b010));
        tick;
        req_val = '0;
        w = 0;
        while (!bf_send_val && w < 20) begin tick; w++; end
        check("rstwait.pending", OPW'(bf_send_val), OPW'(1));
        check("rstwait.in_wait", OPW'(bf_send_rdy), OPW'(1));
        reset = 1'b0;
        #1;
        check("rstwait.busy", OPW'(busy), '0);
        check("rstwait.send_rdy", OPW'(bf_send_rdy), '0);
        check("rstwait.resp_val", OPW'(resp_val), '0);
        check("rstwait.bf_reset", OPW'(bf_reset), OPW'(1));
        check("rstwait.owner", OPW'(owner), '0);
        check("rstwait.bf_op", bf_op, '0);
        check("rstwait.resp_data", OPW'(resp_data), '0);
        tick;
        reset = 1'b1;
        model_ptr = 0;
        for (int k = 0; k < NREQ; k++) begin
            op = '0;
            op[5*N*B +: N] = N'(k + 1);
            req_data[k*OPW +: OPW] = op;
        end
        req_val = '1;
        #1;
        check("rstwait.no_grant_0", OPW'(req_rdy), '0);
        tick;
        check("rstwait.bf_reset_e1", OPW'(bf_reset), OPW'(1));
        check("rstwait.no_grant_1", OPW'(req_rdy), '0);
        tick;
        check("rstwait.bf_reset_e2", OPW'(bf_reset), '0);
        check("rstwait.first_grant", OPW'(req_rdy), OPW'(3'b001));

        // Round-robin with all requesters held valid: 0,1,2,0.
        serve("rr0", 0, 0);
        serve("rr1", 0, 0);
        serve("rr2", 0, 0);
        serve("rr3", 0, 0);

        // Response backpressure on requester 0.
        req_val = 3'b001;
        serve("bp", 0, 10);

        // Wrap and fairness: 2 first, then 0 and 2 together.
        req_val = 3'b100;
        serve("wrap2", 0, 0);
        req_val = 3'b101;
        serve("fair0", 0, 0);
        serve("fair2", 0, 0);

        // Butterfly input stall.
        req_data[1*OPW +: OPW] = op1;
        req_val = 3'b010;
        serve("bfstall", 5, 0);

        // Random requests, operands and stalls.
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NREQ; k++) begin
                for (int wd = 0; wd < OPW / 32; wd++) req_data[k*OPW + wd*32 +: 32] = $urandom();
            end
            req_val = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            serve($sformatf("rand%0d", it), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        req_val = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
